// File: rtl/sws_axil_v2.sv
// rtl/sws_axil_v2.sv - AXI4-Lite debounced switch input peripheral with change interrupts
// Define SWS_IRQ_EN to build the IRQ_EN/IRQ_STAT registers and irq_o; otherwise they read 0.
module sws_axil_v2 #(
    parameter int NUM_SW             = 16,
    parameter int DEBOUNCE_CYCLES    = 1000000,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [NUM_SW-1:0]               sw_i,
    output logic                            irq_o,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(20);
    localparam logic [AW-3:0] IDX_DATA   = (AW-2)'(0);
    localparam logic [AW-3:0] IDX_RAW    = (AW-2)'(1);
    localparam logic [AW-3:0] IDX_EN     = (AW-2)'(2);
    localparam logic [AW-3:0] IDX_STAT   = (AW-2)'(3);
    localparam logic [AW-3:0] IDX_VER    = (AW-2)'(4);
    localparam logic [DW-1:0] VERSION    = DW'(32'h0002_0000 | NUM_SW);

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;

    logic [NUM_SW-1:0] sync1_q, raw_q, data_q, data_d, toggle;
    logic [CW-1:0]     cnt_q [NUM_SW];
    logic [CW-1:0]     cnt_d [NUM_SW];
    logic [DW-1:0]     rdata_q, rd_mux, en_rd, stat_rd;
    logic [1:0]        rresp_q, bresp_q;
    logic              w_hs, w_err, r_hs, r_err;
    logic [AW-3:0]     w_idx, r_idx;

    assign w_hs  = (wstate_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign r_hs  = (rstate_q == R_IDLE) && S_AXI_ARVALID;
    assign w_err = S_AXI_AWADDR >= ADDR_LIMIT;
    assign r_err = S_AXI_ARADDR >= ADDR_LIMIT;
    assign w_idx = S_AXI_AWADDR[AW-1:2];
    assign r_idx = S_AXI_ARADDR[AW-1:2];

    // Counter runs only while the synchronised input disagrees with the debounced state.
    always_comb begin
        toggle = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            cnt_d[i] = '0;
            if (raw_q[i] != data_q[i]) begin
                if (cnt_q[i] == CNT_LAST) toggle[i] = 1'b1;
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        data_d = data_q ^ toggle;
    end

`ifdef SWS_IRQ_EN
    localparam logic [DW-1:0] SW_MASK = DW'((64'd1 << NUM_SW) - 64'd1);
    logic [DW-1:0] wmask, en_q, en_d, stat_q, stat_d, w1c;
    logic          irq_q;

    // A hardware set on the same edge as a W1C wins.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DW/8; b++) wmask[8*b +: 8] = {8{S_AXI_WSTRB[b]}};
        en_d = en_q;
        w1c  = '0;
        if (w_hs && !w_err && w_idx == IDX_EN)
            en_d = ((en_q & ~wmask) | (S_AXI_WDATA & wmask)) & SW_MASK;
        if (w_hs && !w_err && w_idx == IDX_STAT)
            w1c = S_AXI_WDATA & wmask;
        stat_d = (stat_q & ~w1c) | DW'(toggle);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q   <= '0;
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            stat_q <= stat_d;
            irq_q  <= |(stat_q & en_q);
        end
    end

    assign en_rd   = en_q;
    assign stat_rd = stat_q;
    assign irq_o   = irq_q;
`else
    logic unused_irq;
    assign unused_irq = &{1'b0, S_AXI_WDATA, S_AXI_WSTRB};
    assign en_rd   = '0;
    assign stat_rd = '0;
    assign irq_o   = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        rd_mux = '0;
        if (!r_err) begin
            case (r_idx)
                IDX_DATA: rd_mux = DW'(data_q);
                IDX_RAW:  rd_mux = DW'(raw_q);
                IDX_EN:   rd_mux = en_rd;
                IDX_STAT: rd_mux = stat_rd;
                IDX_VER:  rd_mux = VERSION;
                default:  rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (w_hs) wstate_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (r_hs) rstate_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = w_hs;
        S_AXI_WREADY  = w_hs;
        S_AXI_BVALID  = (wstate_q == W_RESP);
        S_AXI_ARREADY = r_hs;
        S_AXI_RVALID  = (rstate_q == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1_q <= '0;
            raw_q   <= '0;
            data_q  <= '0;
            for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            bresp_q <= 2'b00;
        end else begin
            sync1_q <= sw_i;
            raw_q   <= sync1_q;
            data_q  <= data_d;
            for (int i = 0; i < NUM_SW; i++) cnt_q[i] <= cnt_d[i];
            if (w_hs) bresp_q <= w_err ? 2'b10 : 2'b00;
            if (r_hs) begin
                rdata_q <= rd_mux;
                rresp_q <= r_err ? 2'b10 : 2'b00;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;
    assign S_AXI_BRESP = bresp_q;
endmodule

// File: tb/tb_sws_axil_v2.sv
// tb/tb_sws_axil_v2.sv - directed self-checking bench for sws_axil_v2
module tb_sws_axil_v2;
    localparam int NSW = 16;
    localparam int DB  = 4;
`ifdef SWS_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NSW-1:0] sw;
    logic           irq;
    logic [4:0]     awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, awready, wvalid, wready, bvalid, bready;
    logic           arvalid, arready, rvalid, rready;
    logic [31:0]    wdata, rdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp, rresp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t rst_tab [5];
    vec_t err_tab [7];

    always #5 clk = ~clk;

    sws_axil_v2 #(.NUM_SW(NSW), .DEBOUNCE_CYCLES(DB)) dut (
        .ACLK(clk), .ARESETN(rst_n), .sw_i(sw), .irq_o(irq),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] irqv(input logic [31:0] v);
        return IRQ_BUILT ? v : 32'd0;
    endfunction

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin errors++; $display("FAIL aw_handshake: no AWREADY/WREADY in 50 cycles, expected handshake"); end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin errors++; $display("FAIL b_wait: BVALID=0 after 50 cycles, expected 1"); end
        resp = bresp;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin errors++; $display("FAIL ar_handshake: no ARREADY in 50 cycles, expected handshake"); end
        @(posedge clk);
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin errors++; $display("FAIL r_wait: RVALID=0 after 50 cycles, expected 1"); end
        data = rdata;
        resp = rresp;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic [31:0] d;
        logic [1:0]  r;
        if (v.wr) begin
            axi_write(v.addr, v.wdata, v.strb, r);
            check($sformatf("%s wr 0x%02h bresp", tag, v.addr), 32'(r), 32'(v.exp_resp));
        end else begin
            axi_read(v.addr, d, r);
            check($sformatf("%s rd 0x%02h rdata", tag, v.addr), d, v.exp_data);
            check($sformatf("%s rd 0x%02h rresp", tag, v.addr), 32'(r), 32'(v.exp_resp));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        b_seen;

        rst_tab[0] = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0000_0000, 2'b00};
        rst_tab[1] = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h0000_0000, 2'b00};
        rst_tab[2] = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h0000_0000, 2'b00};
        rst_tab[3] = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0000_0000, 2'b00};
        rst_tab[4] = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h0002_0010, 2'b00};

        err_tab[0] = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h0000_0000, 2'b10};
        err_tab[1] = '{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
        err_tab[2] = '{1'b1, 5'h00, 32'h0000_FFFF, 4'hF, 32'h0,         2'b00};
        err_tab[3] = '{1'b1, 5'h04, 32'h0000_FFFF, 4'hF, 32'h0,         2'b00};
        err_tab[4] = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_00A5, 2'b00};
        err_tab[5] = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_00A5, 2'b00};
        err_tab[6] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h0002_0010, 2'b00};

        rst_n = 1'b0; sw = '0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;

        #12;
        check("reset ready/valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset resp", {28'd0, rresp, bresp}, 32'd0);
        check("reset irq_o", 32'(irq), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec("rst_tab", rst_tab[i]);
        check("irq_o after reset reads", 32'(irq), 32'd0);

        // Steady 0x00A5: RAW after 2 edges, DATA after 2+DB edges.
        @(negedge clk);
        sw = 16'h00A5;
        @(negedge clk);
        check("raw after 1 edge", 32'(dut.raw_q), 32'h0000);
        @(negedge clk);
        check("raw after 2 edges", 32'(dut.raw_q), 32'h00A5);
        repeat (3) @(negedge clk);
        check("data after 5 edges", 32'(dut.data_q), 32'h0000);
        @(negedge clk);
        check("data after 6 edges", 32'(dut.data_q), 32'h00A5);
        axi_read(5'h04, d, r);
        check("RAW reg", d, 32'h0000_00A5);
        axi_read(5'h00, d, r);
        check("DATA reg", d, 32'h0000_00A5);
        axi_read(5'h0C, d, r);
        check("IRQ_STAT after A5", d, irqv(32'h0000_00A5));

        // Drop bit 0, then clear all status bits.
        @(negedge clk);
        sw = 16'h00A4;
        repeat (12) @(negedge clk);
        axi_write(5'h0C, 32'h0000_FFFF, 4'hF, r);
        axi_read(5'h0C, d, r);
        check("IRQ_STAT after W1C all", d, 32'd0);

        // 3-cycle glitch never reaches DATA.
        @(negedge clk);
        sw = 16'h00A5;
        repeat (3) @(negedge clk);
        sw = 16'h00A4;
        repeat (12) @(negedge clk);
        check("data after 3-cycle glitch", 32'(dut.data_q), 32'h00A4);
        axi_read(5'h0C, d, r);
        check("IRQ_STAT after 3-cycle glitch", d, 32'd0);

        // 5-cycle pulse: DATA[0] rises on edge 6, then falls back.
        @(negedge clk);
        sw = 16'h00A5;
        repeat (5) @(negedge clk);
        check("data at edge 5 of pulse", 32'(dut.data_q), 32'h00A4);
        sw = 16'h00A4;
        @(negedge clk);
        check("data at edge 6 of pulse", 32'(dut.data_q), 32'h00A5);
        repeat (12) @(negedge clk);
        check("data after pulse returns", 32'(dut.data_q), 32'h00A4);
        axi_read(5'h0C, d, r);
        check("IRQ_STAT after 5-cycle pulse", d, irqv(32'h1));

        // IRQ_EN with byte strobe; upper byte of WDATA must be ignored.
        axi_write(5'h08, 32'h0000_0F01, 4'b0001, r);
        check("IRQ_EN write bresp", 32'(r), 32'd0);
        axi_read(5'h08, d, r);
        check("IRQ_EN readback", d, irqv(32'h1));
        check("irq_o enabled", 32'(irq), 32'(IRQ_BUILT));

        axi_write(5'h0C, 32'h0000_0001, 4'hF, r);
        check("irq_o on W1C edge", 32'(irq), 32'(IRQ_BUILT));
        @(negedge clk);
        check("irq_o after W1C edge", 32'(irq), 32'd0);

        // W1C handshake lands on the same edge as a channel-0 toggle.
        @(negedge clk);
        sw = 16'h00A5;
        repeat (4) @(negedge clk);
        axi_write(5'h0C, 32'h0000_0001, 4'hF, r);
        check("data toggled on W1C edge", 32'(dut.data_q), 32'h00A5);
        check("irq_o same edge as set", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_o one edge after set", 32'(irq), 32'(IRQ_BUILT));
        axi_read(5'h0C, d, r);
        check("IRQ_STAT set wins over W1C", d, irqv(32'h1));

        for (int i = 0; i < 7; i++) run_vec("err_tab", err_tab[i]);

        // Reset while a B beat is stalled.
        @(negedge clk);
        bready = 1'b0;
        awaddr = 5'h08; wdata = 32'h0000_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        for (int n = 0; n < 50 && !(awready && wready); n++) begin @(negedge clk); #1; end
        @(posedge clk);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid stalled before reset", 32'(bvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("bvalid during reset", 32'(bvalid), 32'd0);
        check("irq_o during reset", 32'(irq), 32'd0);
        check("data during reset", 32'(dut.data_q), 32'd0);
        check("raw during reset", 32'(dut.raw_q), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            b_seen = b_seen | bvalid;
        end
        check("no B beat after reset release", 32'(b_seen), 32'd0);
        bready = 1'b1;
        axi_read(5'h08, d, r);
        check("IRQ_EN after reset", d, 32'd0);
        check("IRQ_EN after reset rresp", 32'(r), 32'd0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
